// File: rtl/gpio_input_conditioner.sv
// Push-button and DIP-switch conditioner: 2-FF synchroniser, per-bit debounce counter,
// and registered level/edge outputs, all on the single i_clk domain.
module gpio_input_conditioner #(
   parameter int N_BTN           = 5,
   parameter int N_SW            = 8,
   parameter int DEBOUNCE_CYCLES = 742500,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_BTN-1:0] i_push_btn,
   input  logic [N_SW-1:0]  i_DIP_sw,
   output logic [N_BTN-1:0] o_btn,
   output logic [N_BTN-1:0] o_btn_press,
   output logic [N_BTN-1:0] o_btn_release,
   output logic [N_SW-1:0]  o_sw,
   output logic             o_sw_changed
);

   localparam int N_BIT = N_BTN + N_SW;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BIT-1:0] pad_raw;
   logic [N_BIT-1:0] sync_p0;
   logic [N_BIT-1:0] sync_p1;
   logic [N_BIT-1:0] stable_p2;
   logic [N_BIT-1:0] accept;
   logic [CNT_W-1:0] cnt_p2 [N_BIT];
   logic [N_BTN-1:0] press_p2;
   logic [N_BTN-1:0] release_p2;
   logic             sw_changed_p2;

   // Buttons occupy the low bits, switches the high bits of every per-bit vector.
   assign pad_raw = {i_DIP_sw, i_push_btn};

   // Stage p0/p1: two-flop synchroniser for the asynchronous pads.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= pad_raw;
         sync_p1 <= sync_p0;
      end
   end

   // A bit is accepted when it has disagreed with the stable level for the full window.
   always_comb begin
      accept = '0;
      for (int i = 0; i < N_BIT; i++) begin
         accept[i] = (sync_p1[i] != stable_p2[i]) && (cnt_p2[i] == CNT_LAST);
      end
   end

   // Stage p2: debounce counters, stable levels and edge pulses update together.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         stable_p2     <= '0;
         press_p2      <= '0;
         release_p2    <= '0;
         sw_changed_p2 <= 1'b0;
         for (int i = 0; i < N_BIT; i++) begin
            cnt_p2[i] <= '0;
         end
      end else begin
         stable_p2     <= stable_p2 ^ accept;
         press_p2      <= accept[N_BTN-1:0] & sync_p1[N_BTN-1:0];
         release_p2    <= accept[N_BTN-1:0] & ~sync_p1[N_BTN-1:0];
         sw_changed_p2 <= |accept[N_BIT-1:N_BTN];
         for (int i = 0; i < N_BIT; i++) begin
            if ((sync_p1[i] == stable_p2[i]) || accept[i]) begin
               cnt_p2[i] <= '0;
            end else begin
               cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
            end
         end
      end
   end

   assign o_btn         = stable_p2[N_BTN-1:0];
   assign o_sw          = stable_p2[N_BIT-1:N_BTN];
   assign o_btn_press   = press_p2;
   assign o_btn_release = release_p2;
   assign o_sw_changed  = sw_changed_p2;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4: a run-length model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_gpio_input_conditioner;

   localparam int NB = 5;
   localparam int NS = 8;
   localparam int DC = 4;
   localparam int NT = NB + NS;

   logic          clk = 1'b0;
   logic          i_reset;
   logic [NB-1:0] i_push_btn;
   logic [NS-1:0] i_DIP_sw;
   logic [NB-1:0] o_btn, o_btn_press, o_btn_release;
   logic [NS-1:0] o_sw;
   logic          o_sw_changed;

   int n_checks = 0;
   int n_pass   = 0;

   gpio_input_conditioner #(
      .N_BTN(NB), .N_SW(NS), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_push_btn(i_push_btn), .i_DIP_sw(i_DIP_sw),
      .o_btn(o_btn), .o_btn_press(o_btn_press), .o_btn_release(o_btn_release),
      .o_sw(o_sw), .o_sw_changed(o_sw_changed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: a level is adopted once the synchronised pad has shown the same
   // value for DC consecutive edges and that value differs from the current level.
   logic [NT-1:0] m_s1, m_s2, m_stab, m_acc, s_pad;
   logic [NB-1:0] m_press, m_rel;
   logic          m_chg, s_rst;
   int            run_len [NT];
   logic          run_val [NT];

   initial begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_press = '0; m_rel = '0; m_chg = 1'b0;
      for (int i = 0; i < NT; i++) begin run_len[i] = 0; run_val[i] = 1'b0; end
      forever begin
         @(posedge clk);
         s_rst = i_reset;
         s_pad = {i_DIP_sw, i_push_btn};
         @(negedge clk);
         if (s_rst) begin
            m_s1 = '0; m_s2 = '0; m_stab = '0; m_press = '0; m_rel = '0; m_chg = 1'b0;
            for (int i = 0; i < NT; i++) begin run_len[i] = 0; run_val[i] = 1'b0; end
         end else begin
            m_acc = '0;
            for (int i = 0; i < NT; i++) begin
               if (run_len[i] > 0 && run_val[i] == m_s2[i]) run_len[i]++;
               else begin run_val[i] = m_s2[i]; run_len[i] = 1; end
               if (run_len[i] >= DC && m_s2[i] != m_stab[i]) m_acc[i] = 1'b1;
            end
            m_stab  = m_stab ^ m_acc;
            m_press = m_acc[NB-1:0] & m_stab[NB-1:0];
            m_rel   = m_acc[NB-1:0] & ~m_stab[NB-1:0];
            m_chg   = |m_acc[NT-1:NB];
            m_s2 = m_s1;
            m_s1 = s_pad;
         end
         chk("model o_btn", 32'(o_btn), 32'(m_stab[NB-1:0]));
         chk("model o_sw", 32'(o_sw), 32'(m_stab[NT-1:NB]));
         chk("model o_btn_press", 32'(o_btn_press), 32'(m_press));
         chk("model o_btn_release", 32'(o_btn_release), 32'(m_rel));
         chk("model o_sw_changed", 32'(o_sw_changed), 32'(m_chg));
      end
   end

   int cnt_a, cnt_b, at_a;
   logic [NS-1:0] sw_at;

   initial begin
      // Reset with all pads high.
      i_reset = 1'b1; i_push_btn = 5'h1F; i_DIP_sw = 8'hFF;
      @(negedge clk);
      chk("rst o_btn", 32'(o_btn), 32'h0);
      chk("rst o_sw", 32'(o_sw), 32'h0);
      chk("rst press", 32'(o_btn_press), 32'h0);
      chk("rst release", 32'(o_btn_release), 32'h0);
      chk("rst sw_changed", 32'(o_sw_changed), 32'h0);
      @(posedge clk); @(posedge clk); #1 i_reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t1 early o_btn", 32'(o_btn), 32'h0);
      @(posedge clk); @(negedge clk);
      chk("t1 o_btn", 32'(o_btn), 32'h1F);
      chk("t1 press", 32'(o_btn_press), 32'h1F);
      chk("t1 o_sw", 32'(o_sw), 32'hFF);
      chk("t1 sw_changed", 32'(o_sw_changed), 32'h1);
      @(posedge clk); @(negedge clk);
      chk("t1 press width", 32'(o_btn_press), 32'h0);
      chk("t1 changed width", 32'(o_sw_changed), 32'h0);

      // Clean press of button 2 from an all-low state.
      wait_cyc(1); i_push_btn = 5'h00; i_DIP_sw = 8'h00;
      wait_cyc(10);
      i_push_btn[2] = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t2 early o_btn", 32'(o_btn), 32'h0);
      @(posedge clk); @(negedge clk);
      chk("t2 o_btn", 32'(o_btn), 32'h04);
      chk("t2 press", 32'(o_btn_press), 32'h04);

      // Bounce on button 0, then hold high.
      wait_cyc(1); i_push_btn[0] = 1'b1;
      wait_cyc(2); i_push_btn[0] = 1'b0;
      wait_cyc(2); i_push_btn[0] = 1'b1;
      wait_cyc(2); i_push_btn[0] = 1'b0;
      wait_cyc(2); i_push_btn[0] = 1'b1;
      cnt_a = 0; cnt_b = 0; at_a = -1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); @(negedge clk);
         if (o_btn_press[0]) begin cnt_a++; at_a = i; end
         if (o_btn_release[0]) cnt_b++;
      end
      chk("t3 press count", 32'(cnt_a), 32'd1);
      chk("t3 press edge", 32'(at_a), 32'd5);
      chk("t3 release count", 32'(cnt_b), 32'd0);

      // Button 1 release coincides with button 3 press.
      wait_cyc(1); i_push_btn[1] = 1'b1;
      wait_cyc(8);
      i_push_btn[1] = 1'b0; i_push_btn[3] = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("t4 release", 32'(o_btn_release), 32'h02);
      chk("t4 press", 32'(o_btn_press), 32'h08);
      chk("t4 o_btn", 32'(o_btn), 32'h0D);

      // DIP switches jump 00 -> A5 and hold.
      wait_cyc(1); i_DIP_sw = 8'hA5;
      cnt_a = 0; at_a = -1; sw_at = '0;
      for (int i = 0; i < 26; i++) begin
         @(posedge clk); @(negedge clk);
         if (o_sw_changed) begin cnt_a++; at_a = i; sw_at = o_sw; end
      end
      chk("t5 change count", 32'(cnt_a), 32'd1);
      chk("t5 change edge", 32'(at_a), 32'd5);
      chk("t5 o_sw at pulse", 32'(sw_at), 32'hA5);

      // Reset mid-count on a button 4 press.
      wait_cyc(1); i_push_btn = 5'h1D;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t6 pre-reset press", 32'(o_btn_press), 32'h0);
      i_reset = 1'b1;
      @(posedge clk); #1 i_reset = 1'b0;
      @(negedge clk);
      chk("t6 rst o_btn", 32'(o_btn), 32'h0);
      chk("t6 rst o_sw", 32'(o_sw), 32'h0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t6 early press", 32'(o_btn_press), 32'h0);
      @(posedge clk); @(negedge clk);
      chk("t6 press", 32'(o_btn_press), 32'h1D);
      chk("t6 o_btn", 32'(o_btn), 32'h1D);
      chk("t6 o_sw", 32'(o_sw), 32'hA5);
      chk("t6 sw_changed", 32'(o_sw_changed), 32'h1);

      wait_cyc(3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
